// File: rtl/pwm_nivel.sv
// 16-step LED PWM driven by a 4-bit brightness level. The level is sampled once per period,
// and period_tick acts as the clock enable for the upstream level generator.
module pwm_nivel #(
    parameter int unsigned PRESC  = 4,
    parameter bit          INVERT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] level,
    output logic       pwm_out,
    output logic       period_tick,
    output logic [3:0] duty_q,
    output logic [3:0] step_cnt
);

    localparam int unsigned     PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    step_q, step_d;
    logic [3:0]    duty_d;
    logic          step_strobe;
    logic          wrap_evt;
    logic          raw_pwm;

    assign step_strobe = en && (presc_q == PRESC_LAST);
    assign wrap_evt    = step_strobe && (step_q == 4'hF);

    always_comb begin
        presc_d = presc_q;
        step_d  = step_q;
        duty_d  = duty_q;
        if (en) begin
            presc_d = step_strobe ? '0 : presc_q + 1'b1;
        end
        if (step_strobe) begin
            step_d = step_q + 4'd1;
        end
        // The level is captured only at the period boundary, so a period in progress never glitches.
        if (wrap_evt) begin
            duty_d = level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            step_q  <= 4'd0;
            duty_q  <= 4'd0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            duty_q  <= duty_d;
        end
    end

    // Compare uses registers only; duty 15 tops out at 15/16 high by design.
    assign raw_pwm     = (step_q < duty_q);
    assign pwm_out     = raw_pwm ^ INVERT;
    assign period_tick = wrap_evt && !rst;
    assign step_cnt    = step_q;

endmodule

// File: tb/tb_pwm_nivel.sv
// Directed bench for pwm_nivel: three instances cover PRESC=4, PRESC=1 and inverted PRESC=2.
module tb_pwm_nivel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] level = 4'd0;

    logic       a_pwm, a_tick, b_pwm, b_tick, c_pwm, c_tick;
    logic [3:0] a_duty, a_step, b_duty, b_step, c_duty, c_step;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_nivel #(.PRESC(4), .INVERT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .level(level),
        .pwm_out(a_pwm), .period_tick(a_tick), .duty_q(a_duty), .step_cnt(a_step)
    );
    pwm_nivel #(.PRESC(1), .INVERT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .level(level),
        .pwm_out(b_pwm), .period_tick(b_tick), .duty_q(b_duty), .step_cnt(b_step)
    );
    pwm_nivel #(.PRESC(2), .INVERT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .level(level),
        .pwm_out(c_pwm), .period_tick(c_tick), .duty_q(c_duty), .step_cnt(c_step)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step into cycle 0 with rst released and all state cleared.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        level = 4'd15;
        next_cycle();
        #1;
        n_cmp++;
        if (a_pwm !== 1'b0 || a_tick !== 1'b0 || a_duty !== 4'd0 || a_step !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_a: pwm=%b tick=%b duty=%0d step=%0d required 0/0/0/0", a_pwm, a_tick, a_duty, a_step);
        end
        n_cmp++;
        if (c_pwm !== 1'b1 || c_tick !== 1'b0 || c_duty !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_c_invert: pwm=%b tick=%b duty=%0d required 1/0/0", c_pwm, c_tick, c_duty);
        end
        n_cmp++;
        if (b_tick !== 1'b0 || b_step !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_b: tick=%b step=%0d required 0/0", b_tick, b_step);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_and_midchange();
        int p, s, d;
        logic exp_pwm, exp_tick;
        do_reset();
        en = 1'b1;
        level = 4'd5;
        for (int k = 0; k < 192; k++) begin
            #1;
            p = k / 64;
            s = (k % 64) / 4;
            d = (p == 0) ? 0 : ((p == 1) ? 5 : 12);
            exp_pwm  = (s < d);
            exp_tick = ((k % 64) == 63);
            n_cmp++;
            if (a_pwm !== exp_pwm) begin
                n_bad++;
                $display("FAIL basic_pwm cycle %0d: got %b required %b", k, a_pwm, exp_pwm);
            end
            n_cmp++;
            if (a_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL basic_tick cycle %0d: got %b required %b", k, a_tick, exp_tick);
            end
            if (k == 64 || k == 127 || k == 128) begin
                n_cmp++;
                if (a_duty !== ((k == 128) ? 4'd12 : 4'd5)) begin
                    n_bad++;
                    $display("FAIL basic_duty cycle %0d: got %0d required %0d", k, a_duty, (k == 128) ? 12 : 5);
                end
            end
            if (k == 90) level = 4'd12;
            next_cycle();
        end
        $display("test_basic_and_midchange done");
    endtask

    task automatic test_en_freeze();
        int e, frz, d, tick_n, t_first, t_second;
        logic exp_pwm, exp_tick;
        logic [3:0] exp_step;
        do_reset();
        level = 4'd9;
        e = 0; frz = 0; tick_n = 0; t_first = -1; t_second = -1;
        for (int t = 0; t < 140; t++) begin
            en = !(e == 93 && frz < 10);
            #1;
            d = ((e / 64) == 0) ? 0 : 9;
            exp_step = 4'((e / 4) % 16);
            exp_pwm  = (((e % 64) / 4) < d);
            exp_tick = en && ((e % 64) == 63);
            n_cmp++;
            if (a_step !== exp_step || a_pwm !== exp_pwm || a_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL freeze t=%0d: step=%0d pwm=%b tick=%b required %0d/%b/%b", t, a_step, a_pwm, a_tick, exp_step, exp_pwm, exp_tick);
            end
            if (a_tick === 1'b1) begin
                if (tick_n == 0) t_first = t;
                if (tick_n == 1) t_second = t;
                tick_n++;
            end
            if (en) e++;
            else frz++;
            next_cycle();
        end
        n_cmp++;
        if (t_first != 63 || t_second != 137) begin
            n_bad++;
            $display("FAIL freeze_tick_times: got %0d,%0d required 63,137", t_first, t_second);
        end
        $display("test_en_freeze done");
    endtask

    task automatic test_reset_on_wrap();
        int highs, ticks_at;
        do_reset();
        en = 1'b1;
        level = 4'd7;
        for (int k = 0; k < 63; k++) next_cycle();
        #1;
        n_cmp++;
        if (a_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_precondition: tick=%b required 1", a_tick);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_dominates_tick: tick=%b required 0", a_tick);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_duty !== 4'd0 || a_step !== 4'd0 || a_pwm !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_on_wrap_state: duty=%0d step=%0d pwm=%b required 0/0/0", a_duty, a_step, a_pwm);
        end
        highs = 0; ticks_at = -1;
        for (int k = 0; k < 64; k++) begin
            if (a_pwm === 1'b1) highs++;
            if (a_tick === 1'b1 && ticks_at < 0) ticks_at = k;
            next_cycle();
            #1;
        end
        n_cmp++;
        if (highs != 0 || ticks_at != 63) begin
            n_bad++;
            $display("FAIL rst_on_wrap_followup: highs=%0d tick_at=%0d required 0,63", highs, ticks_at);
        end
        $display("test_reset_on_wrap done");
    endtask

    task automatic test_presc1();
        logic exp_pwm, exp_tick;
        do_reset();
        en = 1'b1;
        level = 4'd0;
        for (int k = 0; k < 48; k++) begin
            if (k == 16) level = 4'd15;
            #1;
            exp_pwm  = (k >= 32) && ((k % 16) < 15);
            exp_tick = ((k % 16) == 15);
            n_cmp++;
            if (b_pwm !== exp_pwm || b_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL presc1 cycle %0d: pwm=%b tick=%b required %b/%b", k, b_pwm, b_tick, exp_pwm, exp_tick);
            end
            next_cycle();
        end
        $display("test_presc1 done");
    endtask

    task automatic test_invert();
        logic exp_pwm;
        do_reset();
        en = 1'b1;
        level = 4'd3;
        for (int k = 0; k < 64; k++) begin
            #1;
            exp_pwm = !((k >= 32) && ((k - 32) < 6));
            n_cmp++;
            if (c_pwm !== exp_pwm) begin
                n_bad++;
                $display("FAIL invert cycle %0d: pwm=%b required %b", k, c_pwm, exp_pwm);
            end
            next_cycle();
        end
        $display("test_invert done");
    endtask

    task automatic test_back_to_back();
        logic [3:0] lv [0:3];
        int exp_hi [0:4];
        int highs;
        lv[0] = 4'd15; lv[1] = 4'd1; lv[2] = 4'd8; lv[3] = 4'd0;
        exp_hi[0] = 0; exp_hi[1] = 15; exp_hi[2] = 1; exp_hi[3] = 8; exp_hi[4] = 0;
        do_reset();
        en = 1'b1;
        for (int p = 0; p < 5; p++) begin
            level = (p < 4) ? lv[p] : 4'd0;
            highs = 0;
            for (int k = 0; k < 16; k++) begin
                #1;
                if (b_pwm === 1'b1) highs++;
                next_cycle();
            end
            n_cmp++;
            if (highs != exp_hi[p]) begin
                n_bad++;
                $display("FAIL back_to_back period %0d: high=%0d required %0d", p, highs, exp_hi[p]);
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_basic_and_midchange();
        test_en_freeze();
        test_reset_on_wrap();
        test_presc1();
        test_invert();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
